// File: rtl/ex_mem_skid_pkg.sv
// Shared constants for the EX/MEM skid register: bubble field values and memory-op codes.
package ex_mem_skid_pkg;

  localparam int   NOP_REG_ADDR = 0;
  localparam logic WR_ENABLE    = 1'b1;
  localparam logic WR_DISABLE   = 1'b0;
  localparam int   ZERO_WORD    = 0;

  localparam int MEMOP_NONE  = 0;
  localparam int MEMOP_LOAD  = 1;
  localparam int MEMOP_STORE = 2;

  function automatic int pay_width(input int addr_w, input int data_w, input int memop_w);
    return addr_w + 1 + data_w + memop_w + data_w;
  endfunction

endpackage

// File: rtl/ex_mem_slot.sv
// One payload slot: a valid bit plus a payload register.
// The payload register returns to the bubble pattern whenever the slot is emptied.
module ex_mem_slot #(
  parameter int             W      = 8,
  parameter logic [W-1:0]   BUBBLE = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic         valid,
  output logic [W-1:0] q
);

  // Clear wins over load so a flush always drops the incoming entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      q     <= BUBBLE;
    end else if (clear) begin
      valid <= 1'b0;
      q     <= BUBBLE;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end
  end

endmodule

// File: rtl/ex_mem_skid.sv
// EX/MEM pipeline register with valid/ready handshake, optional two-entry skid buffer,
// synchronous flush and a saturating stall counter.
module ex_mem_skid
  import ex_mem_skid_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int MEMOP_W = 4,
  parameter int SKID    = 1,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               ex_valid,
  output logic               ex_ready,
  input  logic [ADDR_W-1:0]  ex_des_addr,
  input  logic               ex_des_exist,
  input  logic [DATA_W-1:0]  ex_des_data,
  input  logic [MEMOP_W-1:0] ex_memop,
  input  logic [DATA_W-1:0]  ex_mem_addr,
  output logic               mem_valid,
  input  logic               mem_ready,
  output logic [ADDR_W-1:0]  mem_des_addr,
  output logic               mem_des_exist,
  output logic [DATA_W-1:0]  mem_des_data,
  output logic [MEMOP_W-1:0] mem_memop,
  output logic [DATA_W-1:0]  mem_mem_addr,
  output logic [1:0]         occupancy,
  output logic [CNT_W-1:0]   stall_cnt
);

  localparam int PAY_W = pay_width(ADDR_W, DATA_W, MEMOP_W);
  localparam logic [PAY_W-1:0] BUBBLE = {ADDR_W'(NOP_REG_ADDR), WR_DISABLE, DATA_W'(ZERO_WORD),
                                         MEMOP_W'(MEMOP_NONE), DATA_W'(ZERO_WORD)};

  logic [PAY_W-1:0] ex_pay;
  logic [PAY_W-1:0] h_d;
  logic [PAY_W-1:0] h_q;
  logic [PAY_W-1:0] s_q;
  logic             h_full;
  logic             s_full;
  logic             h_load;
  logic             h_clear;
  logic             s_load;
  logic             s_clear;
  logic             accept;
  logic             pop;

  assign ex_pay = {ex_des_addr, ex_des_exist, ex_des_data, ex_memop, ex_mem_addr};
  assign accept = ex_valid & ex_ready & ~flush;
  assign pop    = h_full & mem_ready;

  // Slot control; in skid mode ex_ready=0 whenever S is full, so pop-while-S-full never sees an accept.
  always_comb begin
    h_load  = 1'b0;
    h_clear = 1'b0;
    s_load  = 1'b0;
    s_clear = 1'b0;
    h_d     = ex_pay;
    if (flush) begin
      h_clear = 1'b1;
      s_clear = 1'b1;
    end else if (SKID != 0) begin
      if (pop && s_full) begin
        h_load  = 1'b1;
        h_d     = s_q;
        s_clear = 1'b1;
      end else if (accept && (!h_full || pop)) begin
        h_load = 1'b1;
      end else if (accept) begin
        s_load = 1'b1;
      end else if (pop) begin
        h_clear = 1'b1;
      end
    end else begin
      if (accept) begin
        h_load = 1'b1;
      end else if (pop) begin
        h_clear = 1'b1;
      end
    end
  end

  ex_mem_slot #(.W(PAY_W), .BUBBLE(BUBBLE)) u_head (
    .clk   (clk),
    .rst   (rst),
    .load  (h_load),
    .clear (h_clear),
    .d     (h_d),
    .valid (h_full),
    .q     (h_q)
  );

  generate
    if (SKID != 0) begin : g_skid
      ex_mem_slot #(.W(PAY_W), .BUBBLE(BUBBLE)) u_skid (
        .clk   (clk),
        .rst   (rst),
        .load  (s_load),
        .clear (s_clear),
        .d     (ex_pay),
        .valid (s_full),
        .q     (s_q)
      );
      assign ex_ready = ~s_full;
    end else begin : g_single
      logic unused_s_ctrl;
      assign unused_s_ctrl = &{1'b0, s_load, s_clear};
      assign s_full        = 1'b0;
      assign s_q           = BUBBLE;
      assign ex_ready      = ~h_full | mem_ready;
    end
  endgenerate

  assign mem_valid = h_full;
  assign {mem_des_addr, mem_des_exist, mem_des_data, mem_memop, mem_mem_addr} = h_q;
  assign occupancy = {1'b0, h_full} + {1'b0, s_full};

  // Counts refused offers from EX; sticks at all-ones until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (ex_valid && !ex_ready && !flush && !(&stall_cnt)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_ex_mem_skid.sv
// Scoreboard bench for ex_mem_skid: one skid instance (CNT_W=4) and one single-entry instance.
module tb_ex_mem_skid;

  typedef struct packed {
    logic [4:0]  addr;
    logic        exist;
    logic [31:0] data;
    logic [3:0]  memop;
    logic [31:0] maddr;
  } pay_t;

  typedef enum {PH_RESET, PH_STREAM, PH_BACKPRESSURE, PH_FLUSH, PH_SATURATE, PH_MIDRESET, PH_SINGLE} phase_t;

  phase_t phase;
  int     n_checks = 0;
  int     n_fail   = 0;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic        flush, ex_valid, ex_ready, mem_valid, mem_ready;
  pay_t        ex_pay, mem_pay;
  logic [1:0]  occupancy;
  logic [3:0]  stall_cnt;
  pay_t        exp_q[$];
  pay_t        mon_exp;

  logic        s0_flush, s0_ex_valid, s0_ex_ready, s0_mem_valid, s0_mem_ready;
  pay_t        s0_ex_pay, s0_mem_pay;
  logic [1:0]  s0_occupancy;
  logic [15:0] s0_stall_cnt;
  pay_t        s0_q[$];
  pay_t        s0_mon_exp;

  pay_t pA, pB, pC, pD, pF, pH, pI, pE;
  pay_t p;

  always #5 clk = ~clk;

  ex_mem_skid #(.DATA_W(32), .ADDR_W(5), .MEMOP_W(4), .SKID(1), .CNT_W(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .ex_valid      (ex_valid),
    .ex_ready      (ex_ready),
    .ex_des_addr   (ex_pay.addr),
    .ex_des_exist  (ex_pay.exist),
    .ex_des_data   (ex_pay.data),
    .ex_memop      (ex_pay.memop),
    .ex_mem_addr   (ex_pay.maddr),
    .mem_valid     (mem_valid),
    .mem_ready     (mem_ready),
    .mem_des_addr  (mem_pay.addr),
    .mem_des_exist (mem_pay.exist),
    .mem_des_data  (mem_pay.data),
    .mem_memop     (mem_pay.memop),
    .mem_mem_addr  (mem_pay.maddr),
    .occupancy     (occupancy),
    .stall_cnt     (stall_cnt)
  );

  ex_mem_skid #(.DATA_W(32), .ADDR_W(5), .MEMOP_W(4), .SKID(0), .CNT_W(16)) dut_s0 (
    .clk           (clk),
    .rst           (rst),
    .flush         (s0_flush),
    .ex_valid      (s0_ex_valid),
    .ex_ready      (s0_ex_ready),
    .ex_des_addr   (s0_ex_pay.addr),
    .ex_des_exist  (s0_ex_pay.exist),
    .ex_des_data   (s0_ex_pay.data),
    .ex_memop      (s0_ex_pay.memop),
    .ex_mem_addr   (s0_ex_pay.maddr),
    .mem_valid     (s0_mem_valid),
    .mem_ready     (s0_mem_ready),
    .mem_des_addr  (s0_mem_pay.addr),
    .mem_des_exist (s0_mem_pay.exist),
    .mem_des_data  (s0_mem_pay.data),
    .mem_memop     (s0_mem_pay.memop),
    .mem_mem_addr  (s0_mem_pay.maddr),
    .occupancy     (s0_occupancy),
    .stall_cnt     (s0_stall_cnt)
  );

  function automatic pay_t mkPay(input logic [4:0] a, input logic e, input logic [31:0] d,
                                 input logic [3:0] op, input logic [31:0] ma);
    pay_t r;
    r.addr = a; r.exist = e; r.data = d; r.memop = op; r.maddr = ma;
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s (%s): got %0h, expected %0h", name, phase.name(), actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input pay_t pv);
    @(posedge clk);
    #1;
    ex_valid = v;
    ex_pay   = pv;
  endtask

  task automatic applyStimulusS0(input logic v, input pay_t pv);
    @(posedge clk);
    #1;
    s0_ex_valid = v;
    s0_ex_pay   = pv;
  endtask

  // Monitors: every pop must match the oldest expected entry; idle heads must show bubble values.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_valid && mem_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("[TB] FAIL main unexpected pop: got %0h, expected no entry", mem_pay);
        end else begin
          mon_exp = exp_q.pop_front();
          checkOutput("main head payload", 128'(mem_pay), 128'(mon_exp));
        end
      end
      if (!mem_valid) checkOutput("main bubble payload", 128'(mem_pay), 0);
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (s0_mem_valid && s0_mem_ready) begin
        if (s0_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("[TB] FAIL s0 unexpected pop: got %0h, expected no entry", s0_mem_pay);
        end else begin
          s0_mon_exp = s0_q.pop_front();
          checkOutput("s0 head payload", 128'(s0_mem_pay), 128'(s0_mon_exp));
        end
      end
      if (!s0_mem_valid) checkOutput("s0 bubble payload", 128'(s0_mem_pay), 0);
    end
  end

  initial begin
    #100000;
    n_fail++;
    $display("[TB] FAIL watchdog: simulation exceeded time bound");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    phase = PH_RESET;
    rst = 1'b1;
    flush = 1'b0; ex_valid = 1'b0; ex_pay = '0; mem_ready = 1'b0;
    s0_flush = 1'b0; s0_ex_valid = 1'b0; s0_ex_pay = '0; s0_mem_ready = 1'b0;
    #12;
    checkOutput("reset mem_valid", 128'(mem_valid), 0);
    checkOutput("reset occupancy", 128'(occupancy), 0);
    checkOutput("reset stall_cnt", 128'(stall_cnt), 0);
    checkOutput("reset ex_ready", 128'(ex_ready), 1);
    checkOutput("reset s0 mem_valid", 128'(s0_mem_valid), 0);
    checkOutput("reset s0 occupancy", 128'(s0_occupancy), 0);
    #10 rst = 1'b0;

    // Streaming: one accept per cycle, each entry visible the following cycle
    phase = PH_STREAM;
    $display("[TB] phase %s", phase.name());
    for (int i = 0; i < 8; i++) begin
      p = mkPay(5'(i + 1), 1'b1, 32'h10 + i, 4'(i % 3), 32'h1000 + i * 4);
      applyStimulus(1'b1, p);
      mem_ready = 1'b1;
      exp_q.push_back(p);
      @(negedge clk);
      checkOutput("stream ex_ready", 128'(ex_ready), 1);
      if (i > 0) begin
        checkOutput("stream occupancy", 128'(occupancy), 1);
        checkOutput("stream mem_valid", 128'(mem_valid), 1);
      end
    end
    applyStimulus(1'b0, '0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("stream drained mem_valid", 128'(mem_valid), 0);
    checkOutput("stream drained occupancy", 128'(occupancy), 0);
    checkOutput("stream stall_cnt", 128'(stall_cnt), 0);
    checkOutput("stream queue empty", 128'(exp_q.size()), 0);

    // Back-pressure: A in H, B in S, C refused for three cycles
    phase = PH_BACKPRESSURE;
    $display("[TB] phase %s", phase.name());
    pA = mkPay(5'd3, 1'b1, 32'hAAAA0001, 4'd1, 32'h2000);
    pB = mkPay(5'd4, 1'b1, 32'hBBBB0002, 4'd2, 32'h2004);
    pC = mkPay(5'd5, 1'b0, 32'hCCCC0003, 4'd0, 32'h0);
    applyStimulus(1'b1, pA);
    mem_ready = 1'b0;
    exp_q.push_back(pA);
    @(negedge clk);
    checkOutput("bp ex_ready empty", 128'(ex_ready), 1);
    applyStimulus(1'b1, pB);
    exp_q.push_back(pB);
    @(negedge clk);
    checkOutput("bp ex_ready H full", 128'(ex_ready), 1);
    checkOutput("bp occupancy 1", 128'(occupancy), 1);
    applyStimulus(1'b1, pC);
    @(negedge clk);
    checkOutput("bp ex_ready S full", 128'(ex_ready), 0);
    checkOutput("bp occupancy 2", 128'(occupancy), 2);
    @(posedge clk);
    @(posedge clk);
    #1 mem_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp ex_ready ignores mem_ready", 128'(ex_ready), 0);
    checkOutput("bp stall_cnt 2", 128'(stall_cnt), 2);
    @(negedge clk);
    checkOutput("bp ex_ready reopened", 128'(ex_ready), 1);
    checkOutput("bp occupancy after pop", 128'(occupancy), 1);
    checkOutput("bp stall_cnt 3", 128'(stall_cnt), 3);
    exp_q.push_back(pC);
    applyStimulus(1'b0, '0);
    @(negedge clk);
    checkOutput("bp stall_cnt held", 128'(stall_cnt), 3);
    @(negedge clk);
    checkOutput("bp drained mem_valid", 128'(mem_valid), 0);
    checkOutput("bp queue empty", 128'(exp_q.size()), 0);

    // Flush with H and S full and an entry offered
    phase = PH_FLUSH;
    $display("[TB] phase %s", phase.name());
    applyStimulus(1'b1, mkPay(5'd6, 1'b1, 32'h0000A002, 4'd1, 32'h3000));
    mem_ready = 1'b0;
    exp_q.push_back(ex_pay);
    applyStimulus(1'b1, mkPay(5'd7, 1'b1, 32'h0000B002, 4'd2, 32'h3004));
    exp_q.push_back(ex_pay);
    applyStimulus(1'b1, mkPay(5'd8, 1'b1, 32'h0000C002, 4'd0, 32'h0));
    flush = 1'b1;
    @(negedge clk);
    checkOutput("flush ex_ready unaffected", 128'(ex_ready), 0);
    checkOutput("flush occupancy before", 128'(occupancy), 2);
    applyStimulus(1'b0, '0);
    flush = 1'b0;
    exp_q.delete();
    @(negedge clk);
    checkOutput("flush mem_valid", 128'(mem_valid), 0);
    checkOutput("flush occupancy", 128'(occupancy), 0);
    checkOutput("flush ex_ready", 128'(ex_ready), 1);
    checkOutput("flush stall_cnt", 128'(stall_cnt), 3);
    applyStimulus(1'b0, '0);
    mem_ready = 1'b1;
    @(negedge clk);
    checkOutput("flush C dropped", 128'(mem_valid), 0);

    // Saturation: fill both slots then hold a refused offer for 20 cycles
    phase = PH_SATURATE;
    $display("[TB] phase %s", phase.name());
    pD = mkPay(5'd9, 1'b1, 32'h000000D1, 4'd0, 32'h0);
    pF = mkPay(5'd10, 1'b1, 32'h000000D2, 4'd2, 32'h40);
    pE = mkPay(5'd11, 1'b1, 32'h0000EEEE, 4'd1, 32'h44);
    applyStimulus(1'b1, pD);
    mem_ready = 1'b0;
    exp_q.push_back(pD);
    applyStimulus(1'b1, pF);
    exp_q.push_back(pF);
    applyStimulus(1'b1, pE);
    repeat (5) @(posedge clk);
    @(negedge clk);
    checkOutput("sat stall_cnt 8", 128'(stall_cnt), 8);
    repeat (15) @(posedge clk);
    @(negedge clk);
    checkOutput("sat stall_cnt 15", 128'(stall_cnt), 15);

    // Asynchronous reset between clock edges while both slots are full
    phase = PH_MIDRESET;
    $display("[TB] phase %s", phase.name());
    @(posedge clk);
    #3 rst = 1'b1;
    ex_valid = 1'b0;
    exp_q.delete();
    #1;
    checkOutput("midreset mem_valid", 128'(mem_valid), 0);
    checkOutput("midreset mem_des_addr", 128'(mem_pay.addr), 0);
    checkOutput("midreset mem_des_exist", 128'(mem_pay.exist), 0);
    checkOutput("midreset mem_des_data", 128'(mem_pay.data), 0);
    checkOutput("midreset occupancy", 128'(occupancy), 0);
    checkOutput("midreset stall_cnt", 128'(stall_cnt), 0);
    @(posedge clk);
    #3 rst = 1'b0;
    @(negedge clk);
    checkOutput("post reset ex_ready", 128'(ex_ready), 1);

    // Single-entry instance: combinational ready, pop+accept without a bubble, flush
    phase = PH_SINGLE;
    $display("[TB] phase %s", phase.name());
    pF = mkPay(5'd12, 1'b1, 32'h4, 4'd0, 32'h0);
    pD = mkPay(5'd13, 1'b1, 32'h5, 4'd1, 32'h50);
    applyStimulusS0(1'b1, pF);
    s0_mem_ready = 1'b0;
    s0_q.push_back(pF);
    @(negedge clk);
    checkOutput("s0 ex_ready empty", 128'(s0_ex_ready), 1);
    applyStimulusS0(1'b1, pD);
    @(negedge clk);
    checkOutput("s0 ex_ready full", 128'(s0_ex_ready), 0);
    checkOutput("s0 occupancy", 128'(s0_occupancy), 1);
    @(posedge clk);
    @(posedge clk);
    #1 s0_mem_ready = 1'b1;
    @(negedge clk);
    checkOutput("s0 pop+accept ex_ready", 128'(s0_ex_ready), 1);
    checkOutput("s0 stall_cnt", 128'(s0_stall_cnt), 2);
    s0_q.push_back(pD);
    applyStimulusS0(1'b0, '0);
    @(negedge clk);
    checkOutput("s0 no bubble mem_valid", 128'(s0_mem_valid), 1);
    checkOutput("s0 no bubble data", 128'(s0_mem_pay.data), 'h5);
    @(negedge clk);
    checkOutput("s0 drained mem_valid", 128'(s0_mem_valid), 0);
    checkOutput("s0 drained occupancy", 128'(s0_occupancy), 0);
    pH = mkPay(5'd14, 1'b1, 32'h77, 4'd2, 32'h60);
    pI = mkPay(5'd15, 1'b1, 32'h88, 4'd1, 32'h64);
    applyStimulusS0(1'b1, pH);
    s0_mem_ready = 1'b0;
    s0_q.push_back(pH);
    applyStimulusS0(1'b1, pI);
    s0_flush = 1'b1;
    @(negedge clk);
    checkOutput("s0 flush ex_ready", 128'(s0_ex_ready), 0);
    applyStimulusS0(1'b0, '0);
    s0_flush = 1'b0;
    s0_q.delete();
    @(negedge clk);
    checkOutput("s0 flush mem_valid", 128'(s0_mem_valid), 0);
    checkOutput("s0 flush occupancy", 128'(s0_occupancy), 0);
    checkOutput("s0 flush stall_cnt", 128'(s0_stall_cnt), 2);

    checkOutput("final main queue empty", 128'(exp_q.size()), 0);
    checkOutput("final s0 queue empty", 128'(s0_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
